div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  Initiator side of the iterative divider handshake (start/busy/done). Accepts one
//  M-extension divide/remainder op at a time from issue, handles RISC-V corner cases
//  locally, launches iter_div32 otherwise, and returns the tagged result on a
//  CDB-style valid/ready port. Supports pipeline flush and a watchdog timeout.
// PARAMETERS
//  TAG_W    6   ROB tag width
//  TIMEOUT  64  max cycles in WAIT before abort (must exceed divider latency)
// PORTS
//  clk          in   1      clock, all logic on rising edge
//  rst          in   1      synchronous reset, active-high
//  req_valid    in   1      issue request valid
//  req_ready    out  1      controller can accept (combinational: IDLE && !flush)
//  req_op       in   5      10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU
//  req_rs1      in   32     dividend
//  req_rs2      in   32     divisor
//  req_tag      in   TAG_W  ROB tag
//  flush        in   1      kill in-flight op
//  div_start    out  1      one-cycle start pulse to divider (registered)
//  div_op_sel   out  5      held op to divider
//  div_rs1      out  32     held dividend
//  div_rs2      out  32     held divisor
//  div_busy     in   1      divider busy (status only)
//  div_done     in   1      divider result valid (one-cycle pulse)
//  div_result   in   32     divider result, sampled when div_done=1
//  cdb_valid    out  1      result valid
//  cdb_ready    in   1      result consumed
//  cdb_tag      out  TAG_W  tag of result
//  cdb_data     out  32     result
//  cdb_err      out  1      1 = timeout abort or unsupported op; cdb_data=0
// BEHAVIOUR
//  Reset: state=IDLE; div_start, cdb_valid, cdb_err, kill=0; all data/tag regs 0.
//  Accept: req_valid && req_ready; latch op, rs1, rs2, tag.
//  States: IDLE, LAUNCH, WAIT, RESP.
//   IDLE   -> RESP if fast path (result ready next cycle), else -> LAUNCH.
//   LAUNCH div_start=1 this cycle only -> WAIT; cycle counter cleared.
//   WAIT   on div_done: capture div_result -> RESP (or IDLE if kill set).
//          counter reaches TIMEOUT without done: cdb_err=1, data=0 -> RESP
//          (IDLE if kill).
//   RESP   cdb_valid=1, tag/data/err stable; cdb_ready -> IDLE next cycle.
//  Fast path (no div_start):
//   rs2==0: DIV/DIVU -> 32'hFFFFFFFF; REM/REMU -> rs1.
//   DIV and rs1==32'h80000000 and rs2==32'hFFFFFFFF -> 32'h80000000.
//   REM with same operands -> 0.
//   op[4:2]!=3'b101 -> cdb_err=1, data 0.
//  div_done outside WAIT is ignored. div_op_sel/rs1/rs2 held from LAUNCH until IDLE.
//  Flush:
//   IDLE: blocks accept.
//   RESP: drop result, -> IDLE next cycle, with no further cdb_valid.
//   LAUNCH/WAIT: set kill. Divider is not aborted; wait for done/timeout, then
//   -> IDLE with no cdb_valid. kill is cleared on entry to IDLE.
//  Flush and cdb_ready in the same RESP cycle: result counts as dropped; -> IDLE.
//  Min latency (accept to cdb_valid): fast path 1 cycle; divider path
//  2 + divider latency cycles.
// TESTING
//  DIV 10/3 tag 5 -> one div_start pulse; cdb_valid, cdb_data=3, cdb_tag=5.
//  REM -10%3 -> FFFFFFFF; DIVU FFFFFFF6/2 -> 7FFFFFFB; REMU 7%7 -> 0.
//  DIV 100/0 -> FFFFFFFF, REM 100/0 -> 100, and 80000000/FFFFFFFF DIV -> 80000000
//   and REM -> 0; each with no div_start, cdb_valid one cycle after accept.
//  Hold cdb_ready=0 for 5 cycles in RESP -> data/tag stable, req_ready=0 throughout.
//  Flush 3 cycles into WAIT -> no cdb_valid; req_ready returns 1 cycle after div_done.
//  Divider model never asserts done -> after TIMEOUT cycles cdb_valid, cdb_err=1,
//   cdb_data=0.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Issue-side controller for the iterative divider: accepts one M-extension div/rem op,
// resolves RISC-V corner cases locally, otherwise drives iter_div32 and returns a tagged result.
module div_issue_ctrl #(
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             div_start,
  output logic [4:0]       div_op_sel,
  output logic [31:0]      div_rs1,
  output logic [31:0]      div_rs2,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic [31:0]      div_result,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data,
  output logic             cdb_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [4:0]        op_q;
  logic [31:0]       rs1_q, rs2_q;
  logic [TAG_W-1:0]  tag_q;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic              kill_q, kill_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              div_start_q;

  logic              accept;
  logic              supported, div_zero, overflow, fast;
  logic [31:0]       fast_data;

  // Status only; the handshake relies on div_done and the watchdog.
  logic unused_busy;
  assign unused_busy = div_busy;

  assign accept = req_valid && req_ready;

  // Corner cases the divider is never asked to handle.
  always_comb begin
    supported = (req_op[4:2] == 3'b101);
    div_zero  = (req_rs2 == 32'h0);
    overflow  = !req_op[0] && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
    fast      = !supported || div_zero || overflow;
    fast_data = 32'h0;
    if (!supported) begin
      fast_data = 32'h0;
    end else if (div_zero) begin
      fast_data = req_op[1] ? req_rs1 : 32'hFFFF_FFFF;
    end else if (overflow) begin
      fast_data = req_op[1] ? 32'h0 : 32'h8000_0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= 5'h0;
      rs1_q       <= 32'h0;
      rs2_q       <= 32'h0;
      tag_q       <= '0;
      data_q      <= 32'h0;
      err_q       <= 1'b0;
      kill_q      <= 1'b0;
      cnt_q       <= '0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      err_q       <= err_d;
      kill_q      <= kill_d;
      cnt_q       <= cnt_d;
      div_start_q <= (state_d == StLaunch);
      if (accept) begin
        op_q  <= req_op;
        rs1_q <= req_rs1;
        rs2_q <= req_rs2;
        tag_q <= req_tag;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    kill_d  = kill_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (fast) begin
            state_d = StResp;
            data_d  = fast_data;
            err_d   = !supported;
          end else begin
            state_d = StLaunch;
          end
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        kill_d  = kill_q || flush;
        state_d = StWait;
      end
      StWait: begin
        kill_d = kill_q || flush;
        if (div_done) begin
          data_d  = div_result;
          err_d   = 1'b0;
          state_d = (kill_q || flush) ? StIdle : StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          data_d  = 32'h0;
          err_d   = 1'b1;
          state_d = (kill_q || flush) ? StIdle : StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (flush || cdb_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A squashed op must not leak its kill into the next accept.
    if (state_d == StIdle) begin
      kill_d = 1'b0;
    end
  end

  always_comb begin
    req_ready  = (state_q == StIdle) && !flush;
    cdb_valid  = (state_q == StResp);
    cdb_tag    = tag_q;
    cdb_data   = data_q;
    cdb_err    = err_q;
    div_start  = div_start_q;
    div_op_sel = op_q;
    div_rs1    = rs1_q;
    div_rs2    = rs2_q;
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural iterative-divider model.
module tb_div_issue_ctrl;

  localparam int unsigned TagW    = 6;
  localparam int unsigned Timeout = 64;
  localparam int          DivLat  = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready;
  logic [4:0]      req_op;
  logic [31:0]     req_rs1, req_rs2;
  logic [TagW-1:0] req_tag;
  logic            flush;
  logic            div_start;
  logic [4:0]      div_op_sel;
  logic [31:0]     div_rs1, div_rs2;
  logic            div_busy, div_done;
  logic [31:0]     div_result;
  logic            cdb_valid, cdb_ready;
  logic [TagW-1:0] cdb_tag;
  logic [31:0]     cdb_data;
  logic            cdb_err;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int dcnt = 0;
  logic [31:0] dres;
  bit hang = 0;
  logic [38:0] exp_q[$];

  always #5 clk = ~clk;

  div_issue_ctrl #(.TAG_W(TagW), .TIMEOUT(Timeout)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag), .flush(flush),
    .div_start(div_start), .div_op_sel(div_op_sel), .div_rs1(div_rs1), .div_rs2(div_rs2),
    .div_busy(div_busy), .div_done(div_done), .div_result(div_result),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_err(cdb_err)
  );

  // Plain divider: corner operands return a marker so misrouted fast-path ops show up.
  function automatic logic [31:0] div_model(input logic [4:0] op, input logic [31:0] a, b);
    if (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 32'hDEAD_BEEF;
    case (op[1:0])
      2'd0:    return $signed(a) / $signed(b);
      2'd1:    return a / b;
      2'd2:    return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic logic [32:0] ref_result(input logic [4:0] op, input logic [31:0] a, b);
    if (op[4:2] != 3'b101) return {1'b1, 32'h0};
    if (b == 32'h0) return {1'b0, op[1] ? a : 32'hFFFF_FFFF};
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {1'b0, op[1] ? 32'h0 : 32'h8000_0000};
    return {1'b0, div_model(op, a, b)};
  endfunction

  always @(posedge clk) begin
    div_done <= 1'b0;
    if (rst) begin
      dcnt <= 0;
    end else if (div_start) begin
      n_start <= n_start + 1;
      if (!hang) begin
        dcnt <= DivLat;
        dres <= div_model(div_op_sel, div_rs1, div_rs2);
      end
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        div_done   <= 1'b1;
        div_result <= dres;
      end
    end
  end
  assign div_busy = (dcnt != 0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) return;
    end
    check("ready_timeout", 64'(req_ready), 64'd1);
  endtask

  task automatic accept(input logic [4:0] op, input logic [31:0] a, b,
                        input logic [TagW-1:0] tag);
    wait_ready();
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int lat, output bit got);
    lat = 0; got = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      lat++;
      if (cdb_valid) begin
        got = 1;
        break;
      end
    end
    check("valid_seen", 64'(got), 64'd1);
  endtask

  task automatic consume();
    logic [38:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'(exp_q.size()), 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check("cdb_err", 64'(cdb_err), 64'(e[38]));
    check("cdb_tag", 64'(cdb_tag), 64'(e[37:32]));
    check("cdb_data", 64'(cdb_data), 64'(e[31:0]));
    cdb_ready = 1'b1;
    @(posedge clk);
    #1 cdb_ready = 1'b0;
  endtask

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, b,
                       input logic [TagW-1:0] tag, input logic [31:0] exp_d,
                       input logic exp_e, input bit fast);
    int s0, lat;
    bit got;
    s0 = n_start;
    accept(op, a, b, tag);
    exp_q.push_back({exp_e, tag, exp_d});
    wait_valid(Timeout + 20, lat, got);
    if (got) begin
      if (fast) check("fast_lat", 64'(lat), 64'd1);
      consume();
    end
    check("start_cnt", 64'(n_start - s0), fast ? 64'd0 : 64'd1);
  endtask

  initial begin
    int lat, s0;
    bit got;
    logic [32:0] r;
    logic [4:0] op;
    logic [31:0] a, b;
    rst = 1'b1; req_valid = 0; req_op = 0; req_rs1 = 0; req_rs2 = 0; req_tag = 0;
    flush = 0; cdb_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(cdb_valid), 64'd0);
    check("rst_start", 64'(div_start), 64'd0);
    check("rst_out", {cdb_err, cdb_tag, cdb_data, div_rs1[0]}, 64'd0);

    do_op(5'b10100, 32'd10, 32'd3, 6'd5, 32'd3, 1'b0, 0);
    do_op(5'b10110, 32'hFFFF_FFF6, 32'd3, 6'd6, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(5'b10101, 32'hFFFF_FFF6, 32'd2, 6'd7, 32'h7FFF_FFFB, 1'b0, 0);
    do_op(5'b10111, 32'd7, 32'd7, 6'd8, 32'd0, 1'b0, 0);
    do_op(5'b10100, 32'd100, 32'd0, 6'd10, 32'hFFFF_FFFF, 1'b0, 1);
    do_op(5'b10110, 32'd100, 32'd0, 6'd11, 32'd100, 1'b0, 1);
    do_op(5'b10101, 32'd55, 32'd0, 6'd12, 32'hFFFF_FFFF, 1'b0, 1);
    do_op(5'b10111, 32'd55, 32'd0, 6'd13, 32'd55, 1'b0, 1);
    do_op(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 6'd14, 32'h8000_0000, 1'b0, 1);
    do_op(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15, 32'd0, 1'b0, 1);
    do_op(5'b10101, 32'h8000_0000, 32'hFFFF_FFFF, 6'd16, 32'd0, 1'b0, 0);
    do_op(5'b01100, 32'd9, 32'd3, 6'd17, 32'd0, 1'b1, 1);

    for (int i = 0; i < 16; i++) begin
      op = {3'b101, 2'($urandom_range(0, 3))};
      a = $urandom;
      b = (i % 5 == 0) ? 32'h0 : $urandom;
      r = ref_result(op, a, b);
      do_op(op, a, b, 6'(20 + i), r[31:0], r[32],
            (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    end

    // Backpressure in RESP: result held, no new accept.
    accept(5'b10100, 32'd50, 32'd7, 6'd33);
    exp_q.push_back({1'b0, 6'd33, 32'd7});
    wait_valid(Timeout + 20, lat, got);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_data", 64'(cdb_data), 64'd7);
      check("hold_tag", 64'(cdb_tag), 64'd33);
      check("hold_ready", {cdb_valid, req_ready}, 64'b10);
    end
    consume();

    // Flush a few cycles into WAIT: op dies silently after div_done.
    accept(5'b10100, 32'd1000, 32'd10, 6'd9);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      check("wflush_valid", 64'(cdb_valid), 64'd0);
      check("wflush_ready", 64'(req_ready), 64'd0);
      got = div_done;
    end
    check("wflush_done", 64'(got), 64'd1);
    @(negedge clk);
    check("wflush_idle", {cdb_valid, req_ready}, 64'b01);

    // Flush in RESP, alone and together with cdb_ready: result dropped.
    for (int k = 0; k < 2; k++) begin
      accept(5'b10100, 32'd5, 32'd0, 6'd3);
      @(negedge clk);
      check("rflush_valid", 64'(cdb_valid), 64'd1);
      flush = 1'b1;
      cdb_ready = (k == 1);
      @(negedge clk);
      flush = 1'b0;
      cdb_ready = 1'b0;
      #1 check("rflush_idle", {cdb_valid, req_ready}, 64'b01);
    end

    // Flush in IDLE blocks accept.
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = 5'b10100; req_rs1 = 1; req_rs2 = 0;
    #1 check("iflush_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1 check("iflush_noacc", {cdb_valid, req_ready}, 64'b01);

    // Divider never finishes: watchdog abort.
    hang = 1;
    s0 = n_start;
    accept(5'b10101, 32'd77, 32'd5, 6'd42);
    exp_q.push_back({1'b1, 6'd42, 32'd0});
    wait_valid(Timeout + 40, lat, got);
    check("to_lat", 64'(lat), 64'(Timeout + 2));
    if (got) consume();
    check("to_start", 64'(n_start - s0), 64'd1);
    hang = 0;
    do_op(5'b10100, 32'd21, 32'd4, 6'd1, 32'd5, 1'b0, 0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
